// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FPU register-file constants
package fp_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_REGS = 32;
    localparam logic [31:0] FP_ONE = 32'h3f800000;

endpackage

// File: rtl/fp_scoreboard.sv
// rtl/fp_scoreboard.sv - busy vector and pending count for outstanding writebacks
module fp_scoreboard #(
    parameter int DEPTH = 32,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          setEn,
    input  logic [AW-1:0] setAddr,
    input  logic          clrEn,
    input  logic [AW-1:0] clrAddr,
    input  logic [AW-1:0] lookAddr1,
    input  logic [AW-1:0] lookAddr2,
    input  logic [AW-1:0] lookAddr3,
    output logic          lookBusy1,
    output logic          lookBusy2,
    output logic          lookBusy3,
    output logic [AW:0]   PendingCount
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;
    logic             setHit;
    logic             clrHit;

    assign setHit = setEn && (setAddr != '0);
    assign clrHit = clrEn && (clrAddr != '0) && busy[clrAddr];

    // Set is applied after clear so a same-register writeback+issue stays busy.
    always_comb begin
        busyNext = busy;
        if (clrEn) busyNext[clrAddr] = 1'b0;
        if (setEn) busyNext[setAddr] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            busy         <= '0;
            PendingCount <= '0;
        end else begin
            busy <= busyNext;
            if (setHit && !clrHit)
                PendingCount <= PendingCount + 1'b1;
            else if (!setHit && clrHit)
                PendingCount <= PendingCount - 1'b1;
        end
    end

    assign lookBusy1 = busy[lookAddr1];
    assign lookBusy2 = busy[lookAddr2];
    assign lookBusy3 = busy[lookAddr3];

endmodule

// File: rtl/fp_regfile_sb.sv
// rtl/fp_regfile_sb.sv - FP register file with bypassed reads and write scoreboard
module fp_regfile_sb
    import fp_pkg::*;
#(
    parameter int               WIDTH       = FP_WIDTH,
    parameter int               DEPTH       = FP_REGS,
    parameter int               AW          = $clog2(DEPTH),
    parameter logic [31:0]      CONST0      = FP_ONE,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [AW-1:0]    ReadRegister1,
    input  logic [AW-1:0]    ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             ReadBusy1,
    output logic             ReadBusy2,
    input  logic [AW-1:0]    WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             RegWrite,
    input  logic [AW-1:0]    IssueRegister,
    input  logic             Issue,
    output logic             IssueReady,
    output logic [AW:0]      PendingCount
);

    localparam logic [WIDTH-1:0] REG0_VALUE = WIDTH'(CONST0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wrHit;
    logic             issueAccept;
    logic             rawBusy1;
    logic             rawBusy2;
    logic             rawBusyIssue;

    assign wrHit = RegWrite && (WriteRegister != '0);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 1; i < DEPTH; i++) mem[i] <= RESET_VALUE;
        end else if (wrHit) begin
            mem[WriteRegister] <= WriteData;
        end
    end

    assign ReadData1 = (ReadRegister1 == '0) ? REG0_VALUE :
                       (wrHit && WriteRegister == ReadRegister1) ? WriteData : mem[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == '0) ? REG0_VALUE :
                       (wrHit && WriteRegister == ReadRegister2) ? WriteData : mem[ReadRegister2];

    // A writeback landing this cycle resolves the hazard on its register.
    assign ReadBusy1   = rawBusy1 && !(RegWrite && WriteRegister == ReadRegister1);
    assign ReadBusy2   = rawBusy2 && !(RegWrite && WriteRegister == ReadRegister2);
    assign IssueReady  = (IssueRegister == '0) ||
                         !(rawBusyIssue && !(RegWrite && WriteRegister == IssueRegister));
    assign issueAccept = Issue && IssueReady && (IssueRegister != '0);

    fp_scoreboard #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_scoreboard (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .setEn       (issueAccept),
        .setAddr     (IssueRegister),
        .clrEn       (wrHit),
        .clrAddr     (WriteRegister),
        .lookAddr1   (ReadRegister1),
        .lookAddr2   (ReadRegister2),
        .lookAddr3   (IssueRegister),
        .lookBusy1   (rawBusy1),
        .lookBusy2   (rawBusy2),
        .lookBusy3   (rawBusyIssue),
        .PendingCount(PendingCount)
    );

endmodule

// File: tb/tb_fp_regfile_sb.sv
// tb/tb_fp_regfile_sb.sv - scoreboard-driven bench for fp_regfile_sb
module tb_fp_regfile_sb;

    localparam int SEL_RD1 = 0, SEL_RD2 = 1, SEL_BUSY1 = 2, SEL_BUSY2 = 3, SEL_READY = 4, SEL_PC = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } expItem_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister, IssueRegister;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic        ReadBusy1, ReadBusy2, RegWrite, Issue, IssueReady;
    logic [5:0]  PendingCount;

    int          nCompared = 0;
    int          nMismatched = 0;
    expItem_t    expQ[$];

    logic [31:0] mMem [32];
    logic        mBusy [32];

    always #5 Clk = ~Clk;

    fp_regfile_sb dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .ReadBusy1    (ReadBusy1),
        .ReadBusy2    (ReadBusy2),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .IssueRegister(IssueRegister),
        .Issue        (Issue),
        .IssueReady   (IssueReady),
        .PendingCount (PendingCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h3f800000;
        if (RegWrite && WriteRegister == a) return WriteData;
        return mMem[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a);
        return (a != 0) && mBusy[a] && !(RegWrite && WriteRegister == a);
    endfunction

    function automatic logic [31:0] model_count();
        int n = 0;
        for (int i = 1; i < 32; i++) if (mBusy[i]) n++;
        return 32'(n);
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RD1:   return ReadData1;
            SEL_RD2:   return ReadData2;
            SEL_BUSY1: return {31'b0, ReadBusy1};
            SEL_BUSY2: return {31'b0, ReadBusy2};
            SEL_READY: return {31'b0, IssueReady};
            default:   return {26'b0, PendingCount};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        expItem_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        expQ.push_back(it);
    endtask

    task automatic push_model(input string tag);
        push({tag, ".rd1"}, SEL_RD1, model_read(ReadRegister1));
        push({tag, ".rd2"}, SEL_RD2, model_read(ReadRegister2));
        push({tag, ".busy1"}, SEL_BUSY1, {31'b0, model_busy(ReadRegister1)});
        push({tag, ".busy2"}, SEL_BUSY2, {31'b0, model_busy(ReadRegister2)});
        push({tag, ".ready"}, SEL_READY, {31'b0, (IssueRegister == 0) || !model_busy(IssueRegister)});
        push({tag, ".pc"}, SEL_PC, model_count());
    endtask

    task automatic drain();
        expItem_t it;
        while (expQ.size() > 0) begin
            it = expQ.pop_front();
            chk(it.tag, observe(it.sel), it.exp);
        end
    endtask

    // Inputs change 1 time unit after a posedge; outputs sampled 2 units later.
    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                         input logic [4:0] wr, input logic [31:0] wd,
                         input logic iss, input logic [4:0] ir, input string tag);
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        Issue         = iss;
        IssueRegister = ir;
        #2;
        push_model(tag);
    endtask

    task automatic tick();
        logic acc;
        @(posedge Clk);
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mMem[i]  = 32'h0;
                mBusy[i] = 1'b0;
            end
        end else begin
            acc = Issue && (IssueRegister != 0) && !model_busy(IssueRegister);
            if (RegWrite && WriteRegister != 0) begin
                mMem[WriteRegister]  = WriteData;
                mBusy[WriteRegister] = 1'b0;
            end
            if (acc) mBusy[IssueRegister] = 1'b1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mMem[i]  = 32'h0;
            mBusy[i] = 1'b0;
        end
        Reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, "rst");
        expQ.delete();
        tick();
        tick();
        Reset_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            drive(5'(a), 5'(31 - a), 0, 0, 0, 0, 0, "rdall");
            push("rdall.c1", SEL_RD1, (a == 0) ? 32'h3f800000 : 32'h0);
            push("rdall.c2", SEL_RD2, (a == 31) ? 32'h3f800000 : 32'h0);
            push("rdall.cpc", SEL_PC, 32'd0);
            push("rdall.crdy", SEL_READY, 32'd1);
            drain();
        end

        drive(0, 0, 0, 0, 0, 1, 5, "iss5");
        push("iss5.rdy", SEL_READY, 32'd1);
        drain();
        tick();
        drive(5, 0, 0, 0, 0, 1, 5, "iss5b");
        push("iss5b.busy", SEL_BUSY1, 32'd1);
        push("iss5b.pc", SEL_PC, 32'd1);
        push("iss5b.rdy", SEL_READY, 32'd0);
        drain();
        tick();
        drive(5, 0, 0, 0, 0, 0, 0, "iss5c");
        push("iss5c.pc", SEL_PC, 32'd1);
        drain();

        drive(5, 0, 1, 5, 32'h40490fdb, 0, 0, "wb5");
        push("wb5.byp", SEL_RD1, 32'h40490fdb);
        push("wb5.busy", SEL_BUSY1, 32'd0);
        drain();
        tick();
        drive(5, 0, 0, 0, 0, 0, 0, "wb5n");
        push("wb5n.pc", SEL_PC, 32'd0);
        push("wb5n.rd", SEL_RD1, 32'h40490fdb);
        drain();

        drive(0, 0, 0, 0, 0, 1, 7, "iss7");
        drain();
        tick();
        drive(7, 0, 1, 7, 32'h3f000000, 1, 7, "wbiss7");
        push("wbiss7.rdy", SEL_READY, 32'd1);
        drain();
        tick();
        drive(7, 0, 0, 0, 0, 0, 0, "wbiss7n");
        push("wbiss7n.rd", SEL_RD1, 32'h3f000000);
        push("wbiss7n.busy", SEL_BUSY1, 32'd1);
        push("wbiss7n.pc", SEL_PC, 32'd1);
        drain();
        drive(7, 0, 1, 7, 32'h3f000001, 0, 0, "clr7");
        drain();
        tick();

        drive(0, 0, 1, 0, 32'hdeadbeef, 1, 0, "r0");
        push("r0.rd", SEL_RD1, 32'h3f800000);
        push("r0.busy", SEL_BUSY1, 32'd0);
        drain();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, "r0n");
        push("r0n.rd", SEL_RD1, 32'h3f800000);
        push("r0n.busy", SEL_BUSY1, 32'd0);
        push("r0n.pc", SEL_PC, 32'd0);
        drain();

        drive(0, 0, 0, 0, 0, 1, 3, "iss3");
        drain();
        tick();
        drive(0, 0, 0, 0, 0, 1, 9, "iss9");
        drain();
        tick();
        drive(3, 9, 0, 0, 0, 0, 0, "pre_rst");
        push("pre_rst.pc", SEL_PC, 32'd2);
        drain();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        drive(3, 9, 0, 0, 0, 0, 0, "post_rst");
        push("post_rst.b3", SEL_BUSY1, 32'd0);
        push("post_rst.b9", SEL_BUSY2, 32'd0);
        push("post_rst.pc", SEL_PC, 32'd0);
        drain();
        drive(3, 9, 1, 3, 32'h12345678, 0, 0, "late_wb");
        drain();
        tick();
        drive(3, 9, 0, 0, 0, 0, 0, "late_wbn");
        push("late_wbn.rd", SEL_RD1, 32'h12345678);
        push("late_wbn.busy", SEL_BUSY1, 32'd0);
        push("late_wbn.pc", SEL_PC, 32'd0);
        drain();

        for (int n = 0; n < 400; n++) begin
            Reset_n = ($urandom_range(0, 59) != 0);
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), "rnd");
            drain();
            tick();
        end
        Reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fp_regfile_sb.md
# fp_regfile_sb

Parametrised floating-point register file with an integrated write scoreboard, the next-generation FP register file for the FPU datapath. It stores `DEPTH` words of `WIDTH` bits, hardwires register 0 to a constant (IEEE-754 1.0 by default), and provides two asynchronous read ports with same-cycle write bypass. It also tracks registers awaiting writeback from multi-cycle FPU operations, so the issue logic can stall on RAW and WAW hazards without an external scoreboard.

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 32: number of registers; power of two, at least 2.
- `AW`, $clog2(DEPTH): address width; derived, not overridden.
- `CONST0`, 32'h3f800000: value of register 0, truncated or zero-extended to `WIDTH`.
- `RESET_VALUE`, 0: value loaded into registers 1..DEPTH-1 on reset.

Ports:
- `Clk`  in  1  clock; all state updates on the positive edge.
- `Reset_n`  in  1  reset; synchronous, active-low.
- `ReadRegister1`, `ReadRegister2`  in  AW  read addresses.
- `ReadData1`, `ReadData2`  out  WIDTH  read data (combinational).
- `ReadBusy1`, `ReadBusy2`  out  1  addressed register has a pending writeback.
- `WriteRegister`  in  AW  writeback address.
- `WriteData`  in  WIDTH  writeback data.
- `RegWrite`  in  1  writeback strobe.
- `IssueRegister`  in  AW  destination of an instruction being issued.
- `Issue`  in  1  issue request.
- `IssueReady`  out  1  issue to `IssueRegister` will be accepted this cycle.
- `PendingCount`  out  AW+1  number of registers currently marked busy.

## Operation
- Storage: registers 1..DEPTH-1 are writable. Register 0 always reads `CONST0` and is never busy. Writes and issues to address 0 are ignored.
- Write: when `RegWrite` is high and `WriteRegister` is nonzero, the register loads `WriteData` at the clock edge. Its busy bit clears at the same edge. A write to a non-busy register is legal and does not change `PendingCount`.
- Read: `ReadDataN` equals the stored value of `ReadRegisterN`. Bypass: if `RegWrite` is high and `WriteRegister == ReadRegisterN != 0`, `ReadDataN` equals `WriteData` in the same cycle.
- `ReadBusyN` = busy[`ReadRegisterN`] AND NOT (`RegWrite` AND `WriteRegister == ReadRegisterN`). A same-cycle writeback therefore resolves the hazard.
- `IssueReady` = (`IssueRegister` == 0) OR NOT `ReadBusy` evaluated for `IssueRegister`, using the same writeback-resolution rule.
- Issue is accepted when `Issue` and `IssueReady` are both high. Acceptance sets busy[`IssueRegister`] at the edge; address 0 is excluded. A request with `IssueReady` low has no effect, and the caller must hold it.
- Simultaneous writeback and accepted issue to the same register: the register takes `WriteData` and busy ends the cycle set, representing the new pending result. `PendingCount` is unchanged.
- `PendingCount` changes by +1 when only a set occurs, −1 when only a clear of a busy bit occurs, and 0 otherwise. It never exceeds DEPTH−1.
- Reset: registers 1..DEPTH-1 load `RESET_VALUE`, all busy bits clear, `PendingCount` = 0. A reset mid-operation discards pending writebacks. A later late writeback simply writes the data and leaves busy clear.

## Timing
- Read latency: 0 cycles, combinational from address, `RegWrite`, `WriteRegister` and `WriteData`.
- Write latency: 1 edge. The stored value is visible without bypass in the cycle after the write.
- Busy set on an accepted issue is visible on `ReadBusyN` and `IssueReady` from the next cycle.
- Output values after reset edge: `ReadDataN` = `RESET_VALUE` (or `CONST0` for address 0); `ReadBusyN` = 0; `IssueReady` = 1; `PendingCount` = 0.
- No combinational path from `Issue` to any output.

## Structure
- Shared package `fp_pkg`: `FP_ONE` = 32'h3f800000 and the `FP_WIDTH`/`FP_REGS` defaults. `CONST0` defaults to `FP_ONE`.
- Sub-module `fp_scoreboard` (parameters `DEPTH`, `AW`): holds the busy vector and `PendingCount`. It takes set/clear requests and produces the busy lookups.
- Top level holds the storage array, the write decode, and two read muxes with bypass.

## Test plan
- Reset then read all addresses: address 0 → 0x3f800000, others → `RESET_VALUE`; `PendingCount` = 0, `IssueReady` = 1.
- Issue to r5, then read r5: `ReadBusy1` = 1 and `PendingCount` = 1. A second issue to r5 sees `IssueReady` = 0 and is ignored.
- Writeback r5 = 0x40490fdb while reading r5: same cycle `ReadData1` = 0x40490fdb and `ReadBusy1` = 0; next cycle `PendingCount` = 0.
- Same-cycle writeback of r7 = 0x3f000000 and issue to r7 with r7 busy: next cycle r7 reads 0x3f000000, busy = 1, `PendingCount` unchanged.
- Write and issue to r0: r0 still reads 0x3f800000, never busy, `PendingCount` stays 0.
- Issue to r3 and r9, assert `Reset_n` low for one cycle, then writeback r3: r3 takes the data, no busy bits set, `PendingCount` = 0.
